// File: rtl/axi4_burst_mgr_if.sv
// AXI4 bus bundle shared by the burst manager and its subordinate.
// Carries the AW/W/B/AR/R channels; ID width is a parameter.
interface axi4_bus_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]     aw_id;
    logic [ADDR_W-1:0]   aw_addr;
    logic [7:0]          aw_len;
    logic [2:0]          aw_size;
    logic [1:0]          aw_burst;
    logic                aw_lock;
    logic [3:0]          aw_cache;
    logic [2:0]          aw_prot;
    logic [3:0]          aw_qos;
    logic                aw_valid;
    logic                aw_ready;

    logic [DATA_W-1:0]   w_data;
    logic [DATA_W/8-1:0] w_strb;
    logic                w_last;
    logic                w_valid;
    logic                w_ready;

    logic [1:0]          b_resp;
    logic                b_valid;
    logic                b_ready;

    logic [ID_W-1:0]     ar_id;
    logic [ADDR_W-1:0]   ar_addr;
    logic [7:0]          ar_len;
    logic [2:0]          ar_size;
    logic [1:0]          ar_burst;
    logic                ar_lock;
    logic [3:0]          ar_cache;
    logic [2:0]          ar_prot;
    logic [3:0]          ar_qos;
    logic                ar_valid;
    logic                ar_ready;

    logic [DATA_W-1:0]   r_data;
    logic [1:0]          r_resp;
    logic                r_last;
    logic                r_valid;
    logic                r_ready;

    modport Manager (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_resp, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos, ar_valid,
        input  ar_ready,
        input  r_data, r_resp, r_last, r_valid,
        output r_ready
    );

    modport Subordinate (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_resp, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos, ar_valid,
        output ar_ready,
        output r_data, r_resp, r_last, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi4_burst_mgr.sv
// AXI4 burst manager: independent read and write engines moving a beat count between
// FIFO-style streams and AXI4, splitting into INCR bursts at MAX_BURST_LEN and 4KB boundaries.
module axi4_burst_mgr #(
    parameter int AXI_ADDR_WIDTH   = 32,
    parameter int AXI_DATA_WIDTH   = 64,
    parameter int DATA_COUNT_WIDTH = 16,
    parameter int MAX_BURST_LEN    = 256,
    parameter int AXI_ID_WIDTH     = 4,
    parameter int WR_ID            = 0,
    parameter int RD_ID            = 0
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,

    input  logic                        wr_start_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   wr_addr_i,
    input  logic [DATA_COUNT_WIDTH-1:0] wr_count_i,
    input  logic [AXI_DATA_WIDTH-1:0]   wr_data_i,
    input  logic                        wr_data_valid_i,
    output logic                        wr_data_ready_o,
    output logic                        wr_busy_o,
    output logic                        wr_done_o,
    output logic [1:0]                  wr_err_o,

    input  logic                        rd_start_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   rd_addr_i,
    input  logic [DATA_COUNT_WIDTH-1:0] rd_count_i,
    output logic [AXI_DATA_WIDTH-1:0]   rd_data_o,
    output logic                        rd_data_valid_o,
    input  logic                        rd_data_ready_i,
    output logic                        rd_busy_o,
    output logic                        rd_done_o,
    output logic [1:0]                  rd_err_o,
    output logic                        rd_last_err_o,

    axi4_bus_if.Manager                 axi_mgr_if
);

    localparam int BPB = AXI_DATA_WIDTH / 8;
    localparam int LB  = $clog2(BPB);
    localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~AXI_ADDR_WIDTH'(BPB - 1);

    typedef enum logic [1:0] {WR_IDLE, WR_AW, WR_W, WR_B} wr_state_e;
    typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_R}       rd_state_e;

    // Beats in the next burst: limited by what is left, the burst cap and the 4KB page.
    function automatic logic [8:0] burst_len(input logic [11:0] a_lo,
                                             input logic [DATA_COUNT_WIDTH-1:0] rem);
        logic [12:0] room;
        logic [8:0]  n;
        room = (13'd4096 - {1'b0, a_lo}) >> LB;
        n    = 9'(MAX_BURST_LEN);
        if (32'(rem) < 32'(n)) n = 9'(rem);
        if (13'(n) > room)     n = 9'(room);
        return n;
    endfunction

    wr_state_e                     wr_state_q, wr_state_d;
    logic [AXI_ADDR_WIDTH-1:0]     wr_addr_q, wr_addr_d;
    logic [DATA_COUNT_WIDTH-1:0]   wr_rem_q, wr_rem_d;
    logic [8:0]                    wr_len_q, wr_len_d, wr_len_c;
    logic [8:0]                    wr_beat_q, wr_beat_d;
    logic [1:0]                    wr_err_q, wr_err_d;
    logic                          wr_done_q, wr_done_d;

    rd_state_e                     rd_state_q, rd_state_d;
    logic [AXI_ADDR_WIDTH-1:0]     rd_addr_q, rd_addr_d;
    logic [DATA_COUNT_WIDTH-1:0]   rd_rem_q, rd_rem_d;
    logic [8:0]                    rd_len_q, rd_len_d, rd_len_c;
    logic [8:0]                    rd_beat_q, rd_beat_d;
    logic [1:0]                    rd_err_q, rd_err_d;
    logic                          rd_lerr_q, rd_lerr_d;
    logic                          rd_done_q, rd_done_d;

    assign wr_len_c = burst_len(wr_addr_q[11:0], wr_rem_q);
    assign rd_len_c = burst_len(rd_addr_q[11:0], rd_rem_q);

    assign axi_mgr_if.aw_id    = AXI_ID_WIDTH'(WR_ID);
    assign axi_mgr_if.aw_addr  = wr_addr_q;
    assign axi_mgr_if.aw_len   = 8'(wr_len_c - 9'd1);
    assign axi_mgr_if.aw_size  = 3'(LB);
    assign axi_mgr_if.aw_burst = 2'b01;
    assign axi_mgr_if.aw_lock  = 1'b0;
    assign axi_mgr_if.aw_cache = 4'd0;
    assign axi_mgr_if.aw_prot  = 3'd0;
    assign axi_mgr_if.aw_qos   = 4'd0;
    assign axi_mgr_if.w_data   = wr_data_i;
    assign axi_mgr_if.w_strb   = '1;

    assign axi_mgr_if.ar_id    = AXI_ID_WIDTH'(RD_ID);
    assign axi_mgr_if.ar_addr  = rd_addr_q;
    assign axi_mgr_if.ar_len   = 8'(rd_len_c - 9'd1);
    assign axi_mgr_if.ar_size  = 3'(LB);
    assign axi_mgr_if.ar_burst = 2'b01;
    assign axi_mgr_if.ar_lock  = 1'b0;
    assign axi_mgr_if.ar_cache = 4'd0;
    assign axi_mgr_if.ar_prot  = 3'd0;
    assign axi_mgr_if.ar_qos   = 4'd0;

    assign wr_busy_o     = (wr_state_q != WR_IDLE);
    assign wr_done_o     = wr_done_q;
    assign wr_err_o      = wr_err_q;
    assign rd_busy_o     = (rd_state_q != RD_IDLE);
    assign rd_done_o     = rd_done_q;
    assign rd_err_o      = rd_err_q;
    assign rd_last_err_o = rd_lerr_q;

    // A pending done pulse blocks a start in the same cycle, so done wins.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_addr_d  = wr_addr_q;
        wr_rem_d   = wr_rem_q;
        wr_len_d   = wr_len_q;
        wr_beat_d  = wr_beat_q;
        wr_err_d   = wr_err_q;
        wr_done_d  = 1'b0;
        axi_mgr_if.aw_valid = 1'b0;
        axi_mgr_if.w_valid  = 1'b0;
        axi_mgr_if.w_last   = 1'b0;
        axi_mgr_if.b_ready  = 1'b0;
        wr_data_ready_o     = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                if (wr_start_i && !wr_done_q) begin
                    wr_addr_d = wr_addr_i & ALIGN_MASK;
                    wr_rem_d  = wr_count_i;
                    wr_err_d  = 2'b00;
                    if (wr_count_i == '0) wr_done_d  = 1'b1;
                    else                  wr_state_d = WR_AW;
                end
            end
            WR_AW: begin
                axi_mgr_if.aw_valid = 1'b1;
                if (axi_mgr_if.aw_ready) begin
                    wr_len_d   = wr_len_c;
                    wr_beat_d  = 9'd0;
                    wr_addr_d  = wr_addr_q + (AXI_ADDR_WIDTH'(wr_len_c) << LB);
                    wr_rem_d   = wr_rem_q - DATA_COUNT_WIDTH'(wr_len_c);
                    wr_state_d = WR_W;
                end
            end
            WR_W: begin
                axi_mgr_if.w_valid = wr_data_valid_i;
                axi_mgr_if.w_last  = (wr_beat_q == wr_len_q - 9'd1);
                wr_data_ready_o    = wr_data_valid_i & axi_mgr_if.w_ready;
                if (wr_data_valid_i && axi_mgr_if.w_ready) begin
                    wr_beat_d = wr_beat_q + 9'd1;
                    if (wr_beat_q == wr_len_q - 9'd1) wr_state_d = WR_B;
                end
            end
            WR_B: begin
                axi_mgr_if.b_ready = 1'b1;
                if (axi_mgr_if.b_valid) begin
                    if (wr_err_q == 2'b00) wr_err_d = axi_mgr_if.b_resp;
                    if (wr_rem_q != '0) begin
                        wr_state_d = WR_AW;
                    end else begin
                        wr_done_d  = 1'b1;
                        wr_state_d = WR_IDLE;
                    end
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_addr_d  = rd_addr_q;
        rd_rem_d   = rd_rem_q;
        rd_len_d   = rd_len_q;
        rd_beat_d  = rd_beat_q;
        rd_err_d   = rd_err_q;
        rd_lerr_d  = rd_lerr_q;
        rd_done_d  = 1'b0;
        axi_mgr_if.ar_valid = 1'b0;
        axi_mgr_if.r_ready  = 1'b0;
        rd_data_valid_o     = 1'b0;
        rd_data_o           = '0;
        case (rd_state_q)
            RD_IDLE: begin
                if (rd_start_i && !rd_done_q) begin
                    rd_addr_d = rd_addr_i & ALIGN_MASK;
                    rd_rem_d  = rd_count_i;
                    rd_err_d  = 2'b00;
                    rd_lerr_d = 1'b0;
                    if (rd_count_i == '0) rd_done_d  = 1'b1;
                    else                  rd_state_d = RD_AR;
                end
            end
            RD_AR: begin
                axi_mgr_if.ar_valid = 1'b1;
                if (axi_mgr_if.ar_ready) begin
                    rd_len_d   = rd_len_c;
                    rd_beat_d  = 9'd0;
                    rd_addr_d  = rd_addr_q + (AXI_ADDR_WIDTH'(rd_len_c) << LB);
                    rd_rem_d   = rd_rem_q - DATA_COUNT_WIDTH'(rd_len_c);
                    rd_state_d = RD_R;
                end
            end
            RD_R: begin
                axi_mgr_if.r_ready = rd_data_ready_i;
                rd_data_valid_o    = axi_mgr_if.r_valid;
                rd_data_o          = axi_mgr_if.r_data;
                // The beat count is authoritative; r_last is only cross-checked against it.
                if (axi_mgr_if.r_valid && rd_data_ready_i) begin
                    rd_beat_d = rd_beat_q + 9'd1;
                    if (rd_err_q == 2'b00) rd_err_d = axi_mgr_if.r_resp;
                    if (axi_mgr_if.r_last != (rd_beat_q == rd_len_q - 9'd1)) rd_lerr_d = 1'b1;
                    if (rd_beat_q == rd_len_q - 9'd1) begin
                        if (rd_rem_q != '0) begin
                            rd_state_d = RD_AR;
                        end else begin
                            rd_done_d  = 1'b1;
                            rd_state_d = RD_IDLE;
                        end
                    end
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_state_q <= WR_IDLE;
            wr_err_q   <= 2'b00;
            wr_done_q  <= 1'b0;
            rd_state_q <= RD_IDLE;
            rd_err_q   <= 2'b00;
            rd_lerr_q  <= 1'b0;
            rd_done_q  <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_err_q   <= wr_err_d;
            wr_done_q  <= wr_done_d;
            rd_state_q <= rd_state_d;
            rd_err_q   <= rd_err_d;
            rd_lerr_q  <= rd_lerr_d;
            rd_done_q  <= rd_done_d;
        end
    end

    // Address/count/beat registers are always written before use, so they need no reset.
    always_ff @(posedge clk_i) begin
        wr_addr_q <= wr_addr_d;
        wr_rem_q  <= wr_rem_d;
        wr_len_q  <= wr_len_d;
        wr_beat_q <= wr_beat_d;
        rd_addr_q <= rd_addr_d;
        rd_rem_q  <= rd_rem_d;
        rd_len_q  <= rd_len_d;
        rd_beat_q <= rd_beat_d;
    end

endmodule

// File: tb/tb_axi4_burst_mgr.sv
// Directed bench for axi4_burst_mgr: a small AXI4 subordinate model plus stream producer/consumer,
// with every result compared against hand-derived values through immediate assertions.
module tb_axi4_burst_mgr;

    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int DCW = 16;
    localparam logic [63:0] WPAT = 64'hCAFE_0000_0000_0000;
    localparam logic [63:0] RPAT = 64'hD00D_0000_0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rstn;
    logic           wr_start, rd_start;
    logic [AW-1:0]  wr_addr, rd_addr;
    logic [DCW-1:0] wr_count, rd_count;
    logic [DW-1:0]  wr_data, rd_data;
    logic           wr_data_valid, wr_data_ready, wr_busy, wr_done;
    logic           rd_data_valid, rd_data_ready, rd_busy, rd_done, rd_last_err;
    logic [1:0]     wr_err, rd_err;

    axi4_bus_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(4)) bus ();

    axi4_burst_mgr #(
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .DATA_COUNT_WIDTH(DCW),
        .MAX_BURST_LEN(256), .AXI_ID_WIDTH(4), .WR_ID(0), .RD_ID(0)
    ) dut (
        .clk_i(clk), .rstn_i(rstn),
        .wr_start_i(wr_start), .wr_addr_i(wr_addr), .wr_count_i(wr_count),
        .wr_data_i(wr_data), .wr_data_valid_i(wr_data_valid), .wr_data_ready_o(wr_data_ready),
        .wr_busy_o(wr_busy), .wr_done_o(wr_done), .wr_err_o(wr_err),
        .rd_start_i(rd_start), .rd_addr_i(rd_addr), .rd_count_i(rd_count),
        .rd_data_o(rd_data), .rd_data_valid_o(rd_data_valid), .rd_data_ready_i(rd_data_ready),
        .rd_busy_o(rd_busy), .rd_done_o(rd_done), .rd_err_o(rd_err), .rd_last_err_o(rd_last_err),
        .axi_mgr_if(bus)
    );

    int n_asrt = 0;
    int n_fail = 0;
    bit stall = 1'b0;
    bit early_last = 1'b0;
    int e1 = -1;
    int e2 = -1;

    logic [31:0] aw_addr_log[$];
    logic [7:0]  aw_len_log[$];
    logic [31:0] ar_addr_log[$];
    logic [7:0]  ar_len_log[$];
    logic [63:0] wdata_log[$];
    logic        wlast_log[$];
    logic [63:0] rdata_log[$];
    int widx = 0, ridx = 0, n_b = 0;
    int wr_done_cnt = 0, rd_done_cnt = 0;

    // Subordinate model
    logic       w_ready_r, b_valid_r, r_valid_r, r_active;
    logic [1:0] b_resp_r;
    logic [7:0] r_cnt, r_len;

    assign bus.aw_ready = 1'b1;
    assign bus.ar_ready = 1'b1;
    assign bus.w_ready  = w_ready_r;
    assign bus.b_valid  = b_valid_r;
    assign bus.b_resp   = b_resp_r;
    assign bus.r_valid  = r_valid_r;
    assign bus.r_resp   = 2'b00;
    assign bus.r_data   = RPAT + 64'(ridx);
    assign bus.r_last   = r_valid_r && ((r_cnt == r_len) || (early_last && r_cnt == r_len - 8'd1));
    assign wr_data      = WPAT + 64'(widx);

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_ready_r <= 1'b0;
            b_valid_r <= 1'b0;
            b_resp_r  <= 2'b00;
            r_valid_r <= 1'b0;
            r_active  <= 1'b0;
            r_cnt     <= 8'd0;
            r_len     <= 8'd0;
        end else begin
            w_ready_r <= stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.aw_valid && bus.aw_ready) begin
                aw_addr_log.push_back(bus.aw_addr);
                aw_len_log.push_back(bus.aw_len);
            end
            if (bus.w_valid && bus.w_ready) begin
                wdata_log.push_back(bus.w_data);
                wlast_log.push_back(bus.w_last);
                if (bus.w_last) begin
                    b_valid_r <= 1'b1;
                    b_resp_r  <= (n_b == e1) ? 2'b10 : (n_b == e2) ? 2'b11 : 2'b00;
                end
            end
            if (b_valid_r && bus.b_ready) begin
                b_valid_r <= 1'b0;
                n_b       <= n_b + 1;
            end
            if (bus.ar_valid && bus.ar_ready) begin
                ar_addr_log.push_back(bus.ar_addr);
                ar_len_log.push_back(bus.ar_len);
                r_active <= 1'b1;
                r_cnt    <= 8'd0;
                r_len    <= bus.ar_len;
            end
            if (r_valid_r && bus.r_ready) begin
                ridx <= ridx + 1;
                if (r_cnt == r_len) begin
                    r_active  <= 1'b0;
                    r_valid_r <= 1'b0;
                end else begin
                    r_cnt     <= r_cnt + 8'd1;
                    r_valid_r <= stall ? 1'($urandom_range(0, 1)) : 1'b1;
                end
            end else if (r_active && !r_valid_r) begin
                r_valid_r <= stall ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // Stream producer/consumer and done-pulse monitor
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_data_valid <= 1'b0;
            rd_data_ready <= 1'b0;
        end else begin
            wr_data_valid <= stall ? 1'($urandom_range(0, 1)) : 1'b1;
            rd_data_ready <= stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (wr_data_ready) widx <= widx + 1;
            if (rd_data_valid && rd_data_ready) rdata_log.push_back(rd_data);
            if (wr_done) wr_done_cnt <= wr_done_cnt + 1;
            if (rd_done) rd_done_cnt <= rd_done_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_wr(input logic [31:0] a, input logic [15:0] c);
        @(negedge clk);
        wr_addr = a; wr_count = c; wr_start = 1'b1;
        @(negedge clk);
        wr_start = 1'b0;
    endtask

    task automatic start_rd(input logic [31:0] a, input logic [15:0] c);
        @(negedge clk);
        rd_addr = a; rd_count = c; rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
    endtask

    task automatic wait_wr(input int base, input string tag);
        int t;
        t = 0;
        while (wr_done_cnt == base && t < 20000) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        chk({tag, "_wr_done_once"}, 64'(wr_done_cnt - base), 64'd1);
        chk({tag, "_wr_idle"}, 64'(wr_busy), 64'd0);
    endtask

    task automatic wait_rd(input int base, input string tag);
        int t;
        t = 0;
        while (rd_done_cnt == base && t < 20000) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        chk({tag, "_rd_done_once"}, 64'(rd_done_cnt - base), 64'd1);
        chk({tag, "_rd_idle"}, 64'(rd_busy), 64'd0);
    endtask

    task automatic chk_wdata(input int wbase, input int dbase, input int n, input string tag);
        chk({tag, "_wbeats"}, 64'(wdata_log.size() - wbase), 64'(n));
        for (int k = 0; k < n; k++)
            chk({tag, "_wdata"}, wdata_log[wbase + k], WPAT + 64'(dbase + k));
    endtask

    task automatic chk_rdata(input int rbase, input int dbase, input int n, input string tag);
        chk({tag, "_rbeats"}, 64'(rdata_log.size() - rbase), 64'(n));
        for (int k = 0; k < n; k++)
            chk({tag, "_rdata"}, rdata_log[rbase + k], RPAT + 64'(dbase + k));
    endtask

    initial begin
        int a0, w0, d0, b0, r0, q0;
        rstn = 1'b0;
        wr_start = 1'b0; wr_addr = '0; wr_count = '0;
        rd_start = 1'b0; rd_addr = '0; rd_count = '0;
        repeat (3) @(negedge clk);
        chk("rst_wr_busy", 64'(wr_busy), 64'd0);
        chk("rst_wr_done", 64'(wr_done), 64'd0);
        chk("rst_wr_err", 64'(wr_err), 64'd0);
        chk("rst_rd_busy", 64'(rd_busy), 64'd0);
        chk("rst_rd_done", 64'(rd_done), 64'd0);
        chk("rst_rd_err", 64'(rd_err), 64'd0);
        chk("rst_rd_last_err", 64'(rd_last_err), 64'd0);
        chk("rst_aw_valid", 64'(bus.aw_valid), 64'd0);
        chk("rst_w_valid", 64'(bus.w_valid), 64'd0);
        chk("rst_b_ready", 64'(bus.b_ready), 64'd0);
        chk("rst_ar_valid", 64'(bus.ar_valid), 64'd0);
        chk("rst_r_ready", 64'(bus.r_ready), 64'd0);
        chk("rst_rd_valid", 64'(rd_data_valid), 64'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // single-beat write
        a0 = aw_addr_log.size(); w0 = wdata_log.size(); d0 = widx; b0 = wr_done_cnt;
        start_wr(32'h0, 16'd1);
        chk("t1_busy", 64'(wr_busy), 64'd1);
        wait_wr(b0, "t1");
        chk("t1_n_aw", 64'(aw_addr_log.size() - a0), 64'd1);
        chk("t1_aw_addr", 64'(aw_addr_log[a0]), 64'h0);
        chk("t1_aw_len", 64'(aw_len_log[a0]), 64'd0);
        chk("t1_w_last", 64'(wlast_log[w0]), 64'd1);
        chk_wdata(w0, d0, 1, "t1");
        chk("t1_err", 64'(wr_err), 64'd0);

        // 600-beat read: three bursts
        a0 = ar_addr_log.size(); r0 = rdata_log.size(); d0 = ridx; b0 = rd_done_cnt;
        start_rd(32'h0, 16'd600);
        wait_rd(b0, "t2");
        chk("t2_n_ar", 64'(ar_addr_log.size() - a0), 64'd3);
        chk("t2_ar_addr0", 64'(ar_addr_log[a0]), 64'h0);
        chk("t2_ar_addr1", 64'(ar_addr_log[a0 + 1]), 64'h800);
        chk("t2_ar_addr2", 64'(ar_addr_log[a0 + 2]), 64'h1000);
        chk("t2_ar_len0", 64'(ar_len_log[a0]), 64'd255);
        chk("t2_ar_len1", 64'(ar_len_log[a0 + 1]), 64'd255);
        chk("t2_ar_len2", 64'(ar_len_log[a0 + 2]), 64'd87);
        chk_rdata(r0, d0, 600, "t2");
        chk("t2_last_err", 64'(rd_last_err), 64'd0);
        chk("t2_err", 64'(rd_err), 64'd0);

        // 4KB split; unaligned low address bits are dropped
        a0 = aw_addr_log.size(); w0 = wdata_log.size(); d0 = widx; b0 = wr_done_cnt;
        start_wr(32'hFF5, 16'd4);
        wait_wr(b0, "t3");
        chk("t3_n_aw", 64'(aw_addr_log.size() - a0), 64'd2);
        chk("t3_aw_addr0", 64'(aw_addr_log[a0]), 64'hFF0);
        chk("t3_aw_addr1", 64'(aw_addr_log[a0 + 1]), 64'h1000);
        chk("t3_aw_len0", 64'(aw_len_log[a0]), 64'd1);
        chk("t3_aw_len1", 64'(aw_len_log[a0 + 1]), 64'd1);
        chk("t3_w_last", 64'({wlast_log[w0], wlast_log[w0 + 1], wlast_log[w0 + 2], wlast_log[w0 + 3]}), 64'b0101);
        chk_wdata(w0, d0, 4, "t3");

        // concurrent engines under random stalls
        stall = 1'b1;
        a0 = aw_addr_log.size(); w0 = wdata_log.size(); d0 = widx; b0 = wr_done_cnt;
        r0 = rdata_log.size(); q0 = ridx;
        start_wr(32'h2000, 16'd37);
        start_rd(32'h3000, 16'd37);
        chk("t4_both_busy", 64'({wr_busy, rd_busy}), 64'b11);
        wait_wr(b0, "t4");
        wait_rd(rd_done_cnt - 1 + ((rdata_log.size() - r0 == 37) ? 0 : 1), "t4");
        stall = 1'b0;
        chk("t4_aw_len", 64'(aw_len_log[a0]), 64'd36);
        chk("t4_w_last_end", 64'(wlast_log[w0 + 36]), 64'd1);
        chk("t4_w_last_mid", 64'(wlast_log[w0 + 35]), 64'd0);
        chk_wdata(w0, d0, 37, "t4");
        chk_rdata(r0, q0, 37, "t4");

        // bresp SLVERR on burst 2, DECERR on burst 3: first error sticks
        a0 = aw_addr_log.size(); w0 = wdata_log.size(); d0 = widx; b0 = wr_done_cnt;
        e1 = n_b + 1; e2 = n_b + 2;
        start_wr(32'h1FF0, 16'd268);
        wait_wr(b0, "t5");
        chk("t5_n_aw", 64'(aw_addr_log.size() - a0), 64'd3);
        chk("t5_aw_addr1", 64'(aw_addr_log[a0 + 1]), 64'h2000);
        chk("t5_aw_addr2", 64'(aw_addr_log[a0 + 2]), 64'h2800);
        chk("t5_aw_lens", 64'({aw_len_log[a0], aw_len_log[a0 + 1], aw_len_log[a0 + 2]}), 64'h01FF09);
        chk_wdata(w0, d0, 268, "t5");
        chk("t5_err_sticky", 64'(wr_err), 64'h2);
        e1 = -1; e2 = -1;
        b0 = wr_done_cnt;
        start_wr(32'h100, 16'd1);
        chk("t5_err_cleared", 64'(wr_err), 64'h0);
        wait_wr(b0, "t5b");
        chk("t5b_err", 64'(wr_err), 64'h0);

        // zero-length jobs and start colliding with done
        a0 = aw_addr_log.size(); b0 = wr_done_cnt; r0 = rd_done_cnt;
        @(negedge clk);
        wr_addr = 32'h40; wr_count = 16'd0; wr_start = 1'b1;
        rd_addr = 32'h40; rd_count = 16'd0; rd_start = 1'b1;
        @(negedge clk);
        chk("t6_wr_done", 64'(wr_done), 64'd1);
        chk("t6_rd_done", 64'(rd_done), 64'd1);
        chk("t6_wr_busy", 64'(wr_busy), 64'd0);
        wr_count = 16'd5; rd_count = 16'd5;
        @(negedge clk);
        wr_start = 1'b0; rd_start = 1'b0;
        chk("t6_done_width", 64'({wr_done, rd_done}), 64'd0);
        chk("t6_start_dropped", 64'({wr_busy, rd_busy}), 64'd0);
        repeat (3) @(negedge clk);
        chk("t6_no_aw", 64'(aw_addr_log.size() - a0), 64'd0);
        chk("t6_done_counts", 64'({8'(wr_done_cnt - b0), 8'(rd_done_cnt - r0)}), 64'h0101);

        // r_last one beat early
        early_last = 1'b1;
        r0 = rdata_log.size(); d0 = ridx; b0 = rd_done_cnt;
        start_rd(32'h4000, 16'd8);
        wait_rd(b0, "t7");
        early_last = 1'b0;
        chk("t7_last_err", 64'(rd_last_err), 64'd1);
        chk_rdata(r0, d0, 8, "t7");
        b0 = rd_done_cnt;
        start_rd(32'h4100, 16'd2);
        chk("t7_last_err_cleared", 64'(rd_last_err), 64'd0);
        wait_rd(b0, "t7b");

        // reset in the middle of a read burst
        stall = 1'b1;
        r0 = rdata_log.size();
        start_rd(32'h5000, 16'd100);
        for (int t = 0; t < 2000 && rdata_log.size() < r0 + 10; t++) @(negedge clk);
        chk("t8_mid_busy", 64'(rd_busy), 64'd1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("t8_rst_busy", 64'({wr_busy, rd_busy}), 64'd0);
        chk("t8_rst_valids", 64'({rd_data_valid, bus.r_ready, bus.ar_valid, rd_done}), 64'd0);
        chk("t8_rst_data", rd_data, 64'd0);
        chk("t8_rst_errs", 64'({rd_err, rd_last_err, wr_err}), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        stall = 1'b0;
        r0 = rdata_log.size(); d0 = ridx; b0 = rd_done_cnt;
        start_rd(32'h6000, 16'd3);
        wait_rd(b0, "t8");
        chk_rdata(r0, d0, 3, "t8");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
